// File: rtl/queue2_arb_ctrl.sv
// queue2_arb_ctrl: FIFO controller around an external two-port RAM macro.
// Two enqueue requesters share the write port through a round-robin arbiter.
// A single dequeue port reads the head entry straight from the RAM read port.
module queue2_arb_ctrl #(
  parameter  int unsigned WIDTH = 122,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq0_valid,
  output logic             enq0_ready,
  input  logic [WIDTH-1:0] enq0_bits,
  input  logic             enq1_valid,
  output logic             enq1_ready,
  input  logic [WIDTH-1:0] enq1_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic             deq_src,
  output logic [AW:0]      count,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  output logic             R0_clk,
  input  logic [WIDTH-1:0] R0_data,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic             W0_clk,
  output logic [WIDTH-1:0] W0_data
);

  logic [AW-1:0]    r_enq_ptr;
  logic [AW-1:0]    r_deq_ptr;
  logic             r_maybe_full;
  logic             r_prio;
  logic [DEPTH-1:0] r_src_tag;

  logic             w_ptr_match;
  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_diff;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant_idx;
  logic             w_enq_open;
  logic             w_do_enq;
  logic             w_do_deq;

  // Occupancy status; full and empty differ only by maybe_full
  always_comb begin
    w_ptr_match = (r_enq_ptr == r_deq_ptr);
    w_empty     = w_ptr_match && !r_maybe_full;
    w_full      = w_ptr_match && r_maybe_full;
    w_diff      = r_enq_ptr - r_deq_ptr;
  end

  // Round-robin grant from valids and prio only; readies never feed back
  always_comb begin
    w_grant0    = enq0_valid && (!enq1_valid || !r_prio);
    w_grant1    = enq1_valid && (!enq0_valid || r_prio);
    w_grant_idx = w_grant1;
    w_enq_open  = !w_full && !flush && reset_n;
    w_do_enq    = (w_grant0 || w_grant1) && w_enq_open;
    w_do_deq    = deq_valid && deq_ready && !flush;
  end

  // Port drive: handshakes, RAM ports, head payload and occupancy
  always_comb begin
    enq0_ready = w_grant0 && w_enq_open;
    enq1_ready = w_grant1 && w_enq_open;
    deq_valid  = !w_empty && reset_n;
    deq_bits   = R0_data;
    deq_src    = r_src_tag[r_deq_ptr];
    count      = w_full ? (AW+1)'(DEPTH) : {1'b0, w_diff};
    R0_addr    = r_deq_ptr;
    R0_en      = !w_empty;
    R0_clk     = clock;
    W0_addr    = r_enq_ptr;
    W0_en      = w_do_enq;
    W0_clk     = clock;
    W0_data    = w_grant1 ? enq1_bits : enq0_bits;
  end

  // Pointer, fullness, priority and source-tag state; flush clears the queue but keeps prio
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
      r_prio       <= 1'b0;
      r_src_tag    <= '0;
    end else if (flush) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_enq) begin
        r_src_tag[r_enq_ptr] <= w_grant_idx;
        r_enq_ptr            <= r_enq_ptr + AW'(1);
        r_prio               <= ~w_grant_idx;
      end
      if (w_do_deq) begin
        r_deq_ptr <= r_deq_ptr + AW'(1);
      end
      if (w_do_enq != w_do_deq) begin
        r_maybe_full <= w_do_enq;
      end
    end
  end

endmodule

// File: tb/tb_queue2_arb_ctrl.sv
// Bench for queue2_arb_ctrl: directed stimulus with a scoreboard of expected
// dequeue items and a negedge monitor that pops and compares on each dequeue.
module tb_queue2_arb_ctrl;

  localparam int unsigned WIDTH = 122;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 1;

  logic             clock;
  logic             reset_n;
  logic             flush;
  logic             enq0_valid, enq0_ready;
  logic [WIDTH-1:0] enq0_bits;
  logic             enq1_valid, enq1_ready;
  logic [WIDTH-1:0] enq1_bits;
  logic             deq_valid, deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic             deq_src;
  logic [AW:0]      count;
  logic [AW-1:0]    R0_addr, W0_addr;
  logic             R0_en, R0_clk, W0_en, W0_clk;
  logic [WIDTH-1:0] R0_data, W0_data;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH:0]   sb [$];
  int               n_checks = 0;
  int               n_fail   = 0;

  queue2_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq0_valid(enq0_valid), .enq0_ready(enq0_ready), .enq0_bits(enq0_bits),
    .enq1_valid(enq1_valid), .enq1_ready(enq1_ready), .enq1_bits(enq1_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .deq_src(deq_src), .count(count),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM macro model: synchronous write, combinational read
  always @(posedge W0_clk) if (W0_en) mem[W0_addr] <= W0_data;
  assign R0_data = R0_en ? mem[R0_addr] : '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic src, input logic [WIDTH-1:0] bits);
    sb.push_back({src, bits});
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every accepted dequeue must match the oldest expected item
  always @(negedge clock) begin
    if (reset_n && deq_valid && deq_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        chk("deq_bits", 128'(deq_bits), 128'(e[WIDTH-1:0]));
        chk("deq_src", 128'(deq_src), 128'(e[WIDTH]));
      end
    end
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k0, k1;
    logic g;
    reset_n = 1'b0; flush = 1'b0; deq_ready = 1'b0;
    enq0_valid = 1'b1; enq0_bits = '0;
    enq1_valid = 1'b0; enq1_bits = '0;
    #2;
    chk("rst_enq0_ready", 128'(enq0_ready), 0);
    chk("rst_deq_valid", 128'(deq_valid), 0);
    chk("rst_w0_en", 128'(W0_en), 0);
    chk("rst_count", 128'(count), 0);
    cyc(); cyc();

    // Two enq0 writes, full stall with deq, then refill across pointer wrap
    reset_n = 1'b1; enq0_bits = WIDTH'(1);
    settle();
    chk("t1_ready_a", 128'(enq0_ready), 1);
    chk("t1_w0en_a", 128'(W0_en), 1);
    chk("t1_w0data_a", 128'(W0_data), 1);
    chk("t1_count_a", 128'(count), 0);
    chk("t1_noflow", 128'(deq_valid), 0);
    push(1'b0, WIDTH'(1));
    cyc(); enq0_bits = WIDTH'(2);
    settle();
    chk("t1_ready_b", 128'(enq0_ready), 1);
    chk("t1_count_b", 128'(count), 1);
    chk("t1_dvalid_b", 128'(deq_valid), 1);
    push(1'b0, WIDTH'(2));
    cyc(); enq0_bits = WIDTH'(3); deq_ready = 1'b1;
    settle();
    chk("t1_ready_full", 128'(enq0_ready), 0);
    chk("t1_w0en_full", 128'(W0_en), 0);
    chk("t1_count_full", 128'(count), 2);
    cyc();
    settle();
    chk("t3_ready_after", 128'(enq0_ready), 1);
    chk("t3_count_after", 128'(count), 1);
    chk("t3_waddr_wrap", 128'(W0_addr), 0);
    push(1'b0, WIDTH'(3));
    cyc(); enq0_valid = 1'b0;
    settle();
    chk("t3_count_drain", 128'(count), 1);
    cyc();
    settle();
    chk("t3_count_empty", 128'(count), 0);
    chk("t3_dvalid_empty", 128'(deq_valid), 0);

    // Steady count=1 with simultaneous enq/deq
    deq_ready = 1'b0; enq0_valid = 1'b1; enq0_bits = WIDTH'(16'h100);
    settle();
    chk("t4_ready_first", 128'(enq0_ready), 1);
    push(1'b0, WIDTH'(16'h100));
    cyc(); deq_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      enq0_bits = WIDTH'(16'h100 + i);
      settle();
      chk("t4_ready", 128'(enq0_ready), 1);
      chk("t4_count", 128'(count), 1);
      push(1'b0, WIDTH'(16'h100 + i));
      cyc();
    end
    enq0_valid = 1'b0;
    settle();
    chk("t4_count_end", 128'(count), 1);
    cyc();
    settle();
    chk("t4_count_empty", 128'(count), 0);

    // Both requesters continuously; prio is 1 here so the first grant is 1
    k0 = 0; k1 = 0;
    enq0_valid = 1'b1; enq1_valid = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i == 6) deq_ready = 1'b0;
      g = (i % 2 == 0);
      enq0_bits = WIDTH'(16'hA00 + k0);
      enq1_bits = WIDTH'(16'hB00 + k1);
      settle();
      chk("t2_ready0", 128'(enq0_ready), 128'(!g));
      chk("t2_ready1", 128'(enq1_ready), 128'(g));
      chk("t2_count", 128'(count), (i == 0) ? 0 : 1);
      if (g) begin push(1'b1, WIDTH'(16'hB00 + k1)); k1++; end
      else   begin push(1'b0, WIDTH'(16'hA00 + k0)); k0++; end
      cyc();
    end
    enq0_bits = WIDTH'(16'hA00 + k0);
    enq1_bits = WIDTH'(16'hB00 + k1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) deq_ready = 1'b1;
      settle();
      chk("t2_full_r0", 128'(enq0_ready), 0);
      chk("t2_full_r1", 128'(enq1_ready), 0);
      chk("t2_full_w0en", 128'(W0_en), 0);
      chk("t2_full_count", 128'(count), 2);
      cyc();
    end
    settle();
    chk("t2_stall_prio_r0", 128'(enq0_ready), 1);
    chk("t2_stall_prio_r1", 128'(enq1_ready), 0);
    chk("t2_stall_count", 128'(count), 1);
    push(1'b0, WIDTH'(16'hA00 + k0));
    cyc(); enq0_valid = 1'b0; enq1_valid = 1'b0;
    settle();
    chk("t2_count_drain", 128'(count), 1);
    cyc();
    settle();
    chk("t2_count_empty", 128'(count), 0);

    // Flush at count=2 against a dequeue and an enq1 request
    deq_ready = 1'b0; enq0_valid = 1'b1; enq0_bits = WIDTH'(16'hC1);
    settle();
    chk("t5_fill_a", 128'(enq0_ready), 1);
    push(1'b0, WIDTH'(16'hC1));
    cyc(); enq0_bits = WIDTH'(16'hC2);
    settle();
    chk("t5_fill_b", 128'(enq0_ready), 1);
    push(1'b0, WIDTH'(16'hC2));
    cyc();
    enq0_valid = 1'b0; enq1_valid = 1'b1; enq1_bits = WIDTH'(16'hD1);
    flush = 1'b1; deq_ready = 1'b1;
    settle();
    chk("t5_w0en", 128'(W0_en), 0);
    chk("t5_ready1", 128'(enq1_ready), 0);
    chk("t5_ready0", 128'(enq0_ready), 0);
    chk("t5_count", 128'(count), 2);
    sb.delete();
    cyc(); flush = 1'b0; deq_ready = 1'b0; enq1_valid = 1'b0;
    settle();
    chk("t5_dvalid_after", 128'(deq_valid), 0);
    chk("t5_count_after", 128'(count), 0);
    enq0_valid = 1'b1; enq0_bits = WIDTH'(16'hC3); enq1_valid = 1'b1;
    settle();
    chk("t5_prio_r1", 128'(enq1_ready), 1);
    chk("t5_prio_r0", 128'(enq0_ready), 0);
    push(1'b1, WIDTH'(16'hD1));
    cyc(); enq1_valid = 1'b0; deq_ready = 1'b1;
    settle();
    chk("t5_ready0_c3", 128'(enq0_ready), 1);
    chk("t5_count_c3", 128'(count), 1);
    push(1'b0, WIDTH'(16'hC3));
    cyc();

    // Asynchronous reset mid-cycle with count=1 and prio=1
    enq0_bits = WIDTH'(16'hE0); deq_ready = 1'b0;
    settle();
    chk("t6_pre_ready0", 128'(enq0_ready), 1);
    chk("t6_pre_count", 128'(count), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_dvalid", 128'(deq_valid), 0);
    chk("t6_rst_ready0", 128'(enq0_ready), 0);
    chk("t6_rst_ready1", 128'(enq1_ready), 0);
    chk("t6_rst_w0en", 128'(W0_en), 0);
    chk("t6_rst_count", 128'(count), 0);
    sb.delete();
    cyc(); reset_n = 1'b1; enq1_valid = 1'b1; enq1_bits = WIDTH'(16'hD2);
    settle();
    chk("t6_post_count", 128'(count), 0);
    chk("t6_post_dvalid", 128'(deq_valid), 0);
    chk("t6_post_ready0", 128'(enq0_ready), 1);
    chk("t6_post_ready1", 128'(enq1_ready), 0);
    push(1'b0, WIDTH'(16'hE0));
    cyc(); enq0_valid = 1'b0; enq1_valid = 1'b0; deq_ready = 1'b1;
    settle();
    chk("t6_count_one", 128'(count), 1);
    cyc();
    settle();
    chk("t6_count_zero", 128'(count), 0);
    cyc();
    chk("sb_leftover", 128'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/queue2_arb_ctrl.md
Name: queue2_arb_ctrl

Overview:
- Controller that sequences an external DEPTH x WIDTH two-port RAM macro (default 2x122) as a FIFO.
- Shares the RAM between two enqueue requesters through a round-robin arbiter.
- Presents one Decoupled dequeue port.
- Owns the pointers, full/empty tracking, the RAM port drive and flush. Holds no data storage of its own.

Parameters:
- WIDTH, 122, payload width in bits; must match the RAM data width.
- DEPTH, 2, number of entries; power of two, at least 2.
- AW, log2(DEPTH) (1 at default), RAM address width; derived, not overridable.

Ports:
- clock  in  1  single clock for all state; also drives R0_clk and W0_clk.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue contents.
- enq0_valid  in  1  requester 0 valid.
- enq0_ready  out  1  requester 0 accepted.
- enq0_bits  in  WIDTH  requester 0 payload.
- enq1_valid  in  1  requester 1 valid.
- enq1_ready  out  1  requester 1 accepted.
- enq1_bits  in  WIDTH  requester 1 payload.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer accepts head.
- deq_bits  out  WIDTH  head payload; equals R0_data.
- deq_src  out  1  source index of the head entry.
- count  out  AW+1  occupancy, 0..DEPTH.
- R0_addr  out  AW  RAM read address.
- R0_en  out  1  RAM read enable.
- R0_clk  out  1  RAM read clock.
- R0_data  in  WIDTH  RAM read data; combinational from R0_addr/R0_en.
- W0_addr  out  AW  RAM write address.
- W0_en  out  1  RAM write enable.
- W0_clk  out  1  RAM write clock.
- W0_data  out  WIDTH  RAM write data.

Behaviour:
- State:
  - enq_ptr[AW-1:0], deq_ptr[AW-1:0].
  - maybe_full.
  - prio (0 means requester 0 preferred).
  - src_tag[DEPTH-1:0], a flop array holding the source of each entry.
- Reset (reset_n low, asynchronous):
  - All state clears to 0.
  - While reset_n is low, force enq0_ready, enq1_ready, deq_valid and W0_en to 0; count reads 0.
- Status:
  - empty = (enq_ptr == deq_ptr) && !maybe_full.
  - full = (enq_ptr == deq_ptr) && maybe_full.
  - count = full ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH.
- Arbitration:
  - Combinational; depends only on the valids and prio, never on the readies.
  - One valid: grant goes to that requester.
  - Both valid: grant goes to requester prio.
  - enqN_ready = grantN && !full && !flush && reset_n.
  - At most one ready is high in any cycle.
- Enqueue: do_enq = granted valid && its ready.
  - W0_en = do_enq, W0_addr = enq_ptr, W0_data = granted bits.
  - src_tag[enq_ptr] <= granted index.
  - enq_ptr increments mod DEPTH.
  - prio <= ~granted index. Update prio only on do_enq; a stalled grant leaves prio unchanged.
- Dequeue:
  - deq_valid = !empty. R0_addr = deq_ptr. R0_en = !empty.
  - deq_bits = R0_data. deq_src = src_tag[deq_ptr].
  - do_deq = deq_valid && deq_ready && !flush; deq_ptr increments mod DEPTH.
- maybe_full: on the clock edge, if do_enq != do_deq then maybe_full <= do_enq.
- Latency:
  - Data written at edge N is visible on deq_bits from cycle N+1.
  - No flow-through: deq_valid is 0 in the enqueue cycle when the queue is empty.
- Full with deq_ready high: no enqueue that cycle. enq ready stays low because full is registered; no pipe bypass.
- Simultaneous enqueue and dequeue when not full and not empty: both pointers advance; count and maybe_full are unchanged.
- Wrap-around: pointers wrap DEPTH-1 -> 0; full/empty are distinguished only by maybe_full.
- Flush:
  - Has priority over enqueue and dequeue; no RAM write in the flush cycle.
  - Pointers and maybe_full go to 0; prio is unchanged.
  - deq_valid is 0 from the next cycle.
- Reset asserted mid-transfer: contents are abandoned; RAM data is not cleared and must not be observed (deq_valid is 0).
- R0_clk = W0_clk = clock, passed through directly; no gating.

Test Plan:
- Reset, then enq0 sends 0x1 and 0x2 on consecutive cycles -> both accepted; count=2; enq0_ready=0 on the 3rd cycle; deq yields 0x1 then 0x2 with deq_src=0; count returns to 0.
- enq0 and enq1 valid continuously with distinct data, deq_ready=1 -> grants alternate 0,1,0,1 after the first accept; deq_src sequence is 0,1,0,1; no grant while full.
- Fill to count=2, then deq_ready=1 with enq0_valid=1 -> that cycle: deq only, enq0_ready=0; next cycle: enqueue accepted; pointers wrap to 0 correctly.
- count=1 steady state, simultaneous enq and deq for 8 cycles -> count stays 1; data order preserved across 4 pointer wraps.
- count=2, flush=1 together with deq_ready=1 and enq1_valid=1 -> no write (W0_en=0), no enq1_ready; next cycle deq_valid=0 and count=0; prio unchanged.
- Drop reset_n asynchronously mid-cycle with count=1 -> deq_valid, both enq readies and W0_en go to 0 immediately; after release count=0 and requester 0 has priority.
